// File: rtl/bmem_pkg.sv
// bmem_pkg: shared state encoding and geometry for the burst-memory line controller
package bmem_pkg;
    localparam int BEAT_W = 64;
    localparam int BEATS = 4;
    localparam int LINE_W = 256;
    localparam int OFFSET_W = 5;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE} state_t;
endpackage

// File: rtl/line_deserializer.sv
// line_deserializer: assembles read beats into a cache line, cleared on rst
// Ports: clk, rst, en (store beat), idx (beat slot), beat (beat data), line (assembled line)
module line_deserializer #(
    parameter int BEAT_W = bmem_pkg::BEAT_W,
    parameter int BEATS = bmem_pkg::BEATS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [$clog2(BEATS)-1:0]  idx,
    input  logic [BEAT_W-1:0]         beat,
    output logic [BEAT_W*BEATS-1:0]   line
);
    always_ff @(posedge clk) begin
        if (rst) line <= '0;
        else if (en) line[int'(idx)*BEAT_W +: BEAT_W] <= beat;
    end
endmodule

// File: rtl/bmem_burst_ctrl.sv
// bmem_burst_ctrl: converts cache line read/write-back requests into 4-beat burst-memory transfers
// Cache side: req_addr, req_read, req_write, req_wdata -> req_ready, resp_valid, resp_rdata
// Memory side: bmem_addr, bmem_read, bmem_write, bmem_wdata <- bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
// Optional BMEM_ADDR_CHECK_EN adds sticky output err for stray or mis-tagged read beats
module bmem_burst_ctrl #(
    parameter int BEAT_W = bmem_pkg::BEAT_W,
    parameter int BEATS = bmem_pkg::BEATS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              req_addr,
    input  logic                     req_read,
    input  logic                     req_write,
    input  logic [BEAT_W*BEATS-1:0]  req_wdata,
    output logic                     req_ready,
    output logic                     resp_valid,
    output logic [BEAT_W*BEATS-1:0]  resp_rdata,
    output logic [31:0]              bmem_addr,
    output logic                     bmem_read,
    output logic                     bmem_write,
    output logic [BEAT_W-1:0]        bmem_wdata,
    input  logic                     bmem_ready,
    input  logic [31:0]              bmem_raddr,
    input  logic [BEAT_W-1:0]        bmem_rdata,
    input  logic                     bmem_rvalid
`ifdef BMEM_ADDR_CHECK_EN
    ,
    output logic                     err
`endif
);
    import bmem_pkg::*;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    state_t state, state_n;
    logic [CNT_W-1:0] beat;
    logic [31:0] addr_q;
    logic [BEAT_W*BEATS-1:0] line_q;
    logic accept, rd_beat, wr_beat;
    logic unused_bits;
    assign accept = state == IDLE && (req_read || req_write);
    assign rd_beat = state == RD_WAIT && bmem_rvalid;
    assign wr_beat = state == WR_BURST && bmem_ready;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // counter wraps to 0 naturally after the last beat of every burst
    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
            addr_q <= '0;
            line_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= {req_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                line_q <= req_wdata;
            end
            if (rd_beat || wr_beat) beat <= beat + 1'b1;
        end
    end
    // write wins when both requests arrive together
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = req_write ? WR_BURST : (req_read ? RD_REQ : IDLE);
            RD_REQ:   state_n = bmem_ready ? RD_WAIT : RD_REQ;
            RD_WAIT:  state_n = (rd_beat && beat == LAST) ? DONE : RD_WAIT;
            WR_BURST: state_n = (wr_beat && beat == LAST) ? DONE : WR_BURST;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    assign req_ready = state == IDLE;
    assign resp_valid = state == DONE;
    assign bmem_addr = addr_q;
    assign bmem_read = state == RD_REQ;
    assign bmem_write = state == WR_BURST;
    assign bmem_wdata = bmem_write ? line_q[int'(beat)*BEAT_W +: BEAT_W] : '0;
    line_deserializer #(.BEAT_W(BEAT_W), .BEATS(BEATS)) u_deser (
        .clk  (clk),
        .rst  (rst),
        .en   (rd_beat),
        .idx  (beat),
        .beat (bmem_rdata),
        .line (resp_rdata)
    );
`ifdef BMEM_ADDR_CHECK_EN
    assign unused_bits = ^req_addr[OFFSET_W-1:0];
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (bmem_rvalid && (state != RD_WAIT || bmem_raddr != bmem_addr)) err <= 1'b1;
    end
`else
    assign unused_bits = ^{req_addr[OFFSET_W-1:0], bmem_raddr};
`endif
endmodule

// File: tb/tb_bmem_burst_ctrl.sv
// tb_bmem_burst_ctrl: table-driven, hand-sequenced and randomized checks of bmem_burst_ctrl
module tb_bmem_burst_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] req_addr;
    logic req_read, req_write;
    logic [255:0] req_wdata;
    logic req_ready, resp_valid;
    logic [255:0] resp_rdata;
    logic [31:0] bmem_addr;
    logic bmem_read, bmem_write;
    logic [63:0] bmem_wdata;
    logic bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic bmem_rvalid;
`ifdef BMEM_ADDR_CHECK_EN
    logic err;
`endif
    always #5 clk = ~clk;

    bmem_burst_ctrl dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_read(req_read), .req_write(req_write), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
        .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
`ifdef BMEM_ADDR_CHECK_EN
        , .err(err)
`endif
    );

    typedef struct {
        bit rd;
        bit wr;
        logic [31:0] addr;
        logic [255:0] line;
        int stall_at;
        int stall_n;
        logic [31:0] exp_addr;
        bit exp_write;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [31:0] o_addr;
    int o_cmds, o_resps;
    logic [63:0] o_wq[$];
    logic [255:0] o_rdata;
    bit o_lat_ok;
    logic [255:0] last_rdata;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Drives one request and plays the memory side until the completion pulse.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] line,
                           input int stall_at, input int stall_n, input bit rnd);
        int sent = 0;
        int stalled = 0;
        int last_c = -10;
        int resp_c = -1;
        bit cmd_done = 0;
        chk("ready_idle", req_ready, 1);
        req_read = rd;
        req_write = wr;
        req_addr = addr;
        req_wdata = line;
        bmem_rvalid = rnd && ($urandom_range(0, 1) == 1);
        bmem_rdata = {$urandom, $urandom};
        step();
        req_read = 0;
        req_write = 0;
        req_addr = $urandom;
        req_wdata = rand_line();
        o_cmds = 0;
        o_resps = 0;
        o_wq.delete();
        o_addr = bmem_addr;
        for (int cyc = 0; cyc < 200 && resp_c < 0; cyc++) begin
            chk("busy", req_ready, 0);
            chk("addr_const", bmem_addr, o_addr);
            if (resp_valid) begin
                resp_c = cyc;
                o_rdata = resp_rdata;
                o_resps++;
            end
            bmem_rvalid = 0;
            bmem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bmem_write) begin
                if (o_wq.size() == stall_at && stalled < stall_n) begin
                    bmem_ready = 0;
                    stalled++;
                end
                if (bmem_ready) begin
                    o_wq.push_back(bmem_wdata);
                    last_c = cyc;
                end
            end
            if (cmd_done && sent < 4 && (!rnd || $urandom_range(0, 2) != 0)) begin
                bmem_rvalid = 1;
                bmem_rdata = line[sent*64 +: 64];
                bmem_raddr = o_addr;
                sent++;
                last_c = cyc;
            end else if ((!cmd_done || sent == 4) && rnd && $urandom_range(0, 3) == 0) begin
                bmem_rvalid = 1;
                bmem_rdata = {$urandom, $urandom};
            end
            if (bmem_read && bmem_ready) begin
                o_cmds++;
                cmd_done = 1;
            end
            step();
        end
        bmem_rvalid = 0;
        o_lat_ok = resp_c == last_c + 1;
        chk("resp_one_cycle", resp_valid, 0);
        chk("back_idle", req_ready, 1);
    endtask

    task automatic check_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] line,
                             input int sa, input int sn, input bit rnd, input logic [31:0] ea, input bit ew);
        run_txn(rd, wr, addr, line, sa, sn, rnd);
        chk("resp_count", o_resps, 1);
        chk("bmem_addr", o_addr, ea);
        chk("read_cmds", o_cmds, ew ? 0 : 1);
        chk("write_beats", o_wq.size(), ew ? 4 : 0);
        if (ew) begin
            for (int i = 0; i < 4 && i < o_wq.size(); i++) chk("wbeat", o_wq[i], line[i*64 +: 64]);
        end else begin
            chk("rdata", o_rdata, line);
            last_rdata = line;
        end
        chk("latency", o_lat_ok, 1);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1, 0, 32'h0000_1234,
                    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                    0, 0, 32'h0000_1220, 0};
        vecs[1] = '{0, 1, 32'h0000_2040,
                    256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA,
                    2, 3, 32'h0000_2040, 1};
        vecs[2] = '{1, 1, 32'h0000_3F3F,
                    256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0,
                    1, 1, 32'h0000_3F20, 1};
        vecs[3] = '{1, 0, 32'hFFFF_FFFF,
                    256'h8000000000000001_7FFFFFFFFFFFFFFE_00000000000000FF_FF00000000000000,
                    0, 0, 32'hFFFF_FFE0, 0};

        rst = 1;
        req_addr = 0; req_read = 0; req_write = 0; req_wdata = '0;
        bmem_ready = 0; bmem_raddr = 0; bmem_rdata = 0; bmem_rvalid = 0;
        step();
        step();
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_bmem_read", bmem_read, 0);
        chk("rst_bmem_write", bmem_write, 0);
        chk("rst_bmem_addr", bmem_addr, 0);
        chk("rst_bmem_wdata", bmem_wdata, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        rst = 0;
        last_rdata = '0;

        for (int v = 0; v < 4; v++)
            check_txn(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].line,
                      vecs[v].stall_at, vecs[v].stall_n, 0, vecs[v].exp_addr, vecs[v].exp_write);

        // reset in the middle of a read burst
        req_read = 1; req_addr = 32'h0000_5008; bmem_ready = 1;
        step();
        req_read = 0;
        step();
        for (int i = 0; i < 2; i++) begin
            bmem_rvalid = 1; bmem_rdata = {2{32'hA5A5_0000 + i}};
            step();
        end
        rst = 1; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_idle", req_ready, 1);
            chk("abort_no_resp", resp_valid, 0);
            chk("abort_rdata", resp_rdata, 0);
            step();
        end
        bmem_rvalid = 0;
        last_rdata = '0;
        check_txn(1, 0, 32'h0000_6010, rand_line(), 0, 0, 0, 32'h0000_6000, 0);

        // stray read beat while idle must not move the FSM or touch the line
        bmem_rvalid = 1; bmem_raddr = 32'h1234_5678; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        bmem_rvalid = 0;
        chk("stray_idle", req_ready, 1);
        chk("stray_no_resp", resp_valid, 0);
        chk("stray_rdata", resp_rdata, last_rdata);
`ifdef BMEM_ADDR_CHECK_EN
        chk("err_set", err, 1);
        step();
        step();
        chk("err_sticky", err, 1);
        rst = 1;
        step();
        rst = 0;
        chk("err_clear", err, 0);
        last_rdata = '0;
`endif

        for (int n = 0; n < 40; n++) begin
            bit rd, wr;
            logic [31:0] a;
            logic [255:0] l;
            rd = $urandom_range(0, 1) == 1;
            wr = !rd || ($urandom_range(0, 3) == 0);
            a = $urandom;
            l = rand_line();
            chk("rdata_stable", resp_rdata, last_rdata);
            check_txn(rd, wr, a, l, $urandom_range(0, 3), $urandom_range(0, 3), 1, a & 32'hFFFF_FFE0, wr);
            for (int i = 0; i < $urandom_range(0, 2); i++) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bmem_burst_ctrl.md
BMEM_BURST_CTRL -- requirements
Module: bmem_burst_ctrl

Interface
REQ-001 SHALL have parameter BEAT_W, default 64, burst-memory beat width in bits.
REQ-002 SHALL have parameter BEATS, default 4, beats per cache line; the line is BEAT_W*BEATS = 256 bits.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_addr  input  32  line address from the cache side.
REQ-006 req_read  input  1  line read request.
REQ-007 req_write  input  1  line write-back request.
REQ-008 req_wdata  input  256  write-back line data.
REQ-009 req_ready  output  1  high only in IDLE; a request is accepted on a cycle where req_ready and (req_read or req_write) are both high.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  256  assembled read line; valid only with resp_valid after a read.
REQ-012 bmem_addr  output  32  burst address: latched req_addr with bits [4:0] forced to 0.
REQ-013 bmem_read  output  1  read command.
REQ-014 bmem_write  output  1  write beat strobe.
REQ-015 bmem_wdata  output  64  current write beat.
REQ-016 bmem_ready  input  1  memory accepts a command or beat this cycle.
REQ-017 bmem_raddr  input  32  address tag of the returning read data.
REQ-018 bmem_rdata  input  64  returning read beat.
REQ-019 bmem_rvalid  input  1  bmem_rdata is valid.

Function
REQ-020 SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_BURST and DONE.
REQ-021 On accept, SHALL latch addr and wdata, then go to RD_REQ for a read or WR_BURST for a write; if both are asserted, write SHALL win and the read SHALL NOT be accepted.
REQ-022 RD_REQ SHALL drive bmem_read=1 with bmem_addr, and SHALL move to RD_WAIT only on a cycle with bmem_ready=1; the command is held while bmem_ready=0.
REQ-023 RD_WAIT SHALL store beat k of each bmem_rvalid cycle into resp_rdata[64k+63:64k], k=0..3; after the 4th beat SHALL go to DONE; gaps between beats are allowed.
REQ-024 WR_BURST SHALL drive bmem_write=1, bmem_addr constant and bmem_wdata = line[64k+63:64k]; k SHALL advance only when bmem_ready=1; after beat 3 is accepted SHALL go to DONE.
REQ-025 DONE SHALL assert resp_valid for exactly one cycle, then return to IDLE; read latency = 1 cycle after the last beat.
REQ-026 SHALL ignore bmem_rvalid in every state except RD_WAIT.
REQ-027 The 2-bit beat counter SHALL wrap to 0 on burst completion.
REQ-028 At most one bmem_read SHALL be issued per accepted read, and exactly 4 bmem_write beats per accepted write.
REQ-029 SHALL keep resp_rdata stable after DONE until the next read's first beat.

Reset
REQ-030 On rst: state=IDLE, beat counter=0, latched addr/data=0, resp_valid=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, resp_rdata=0.
REQ-031 rst during any burst SHALL abort it with no resp_valid; beats arriving afterwards SHALL be ignored.

Configuration
REQ-032 Macro BMEM_ADDR_CHECK_EN: when defined, SHALL add output err (1 bit, reset 0, sticky until rst), set when bmem_rvalid occurs in RD_WAIT with bmem_raddr != bmem_addr, or occurs outside RD_WAIT.
REQ-033 When BMEM_ADDR_CHECK_EN is undefined, port err and the check logic SHALL NOT exist, with behaviour otherwise identical.

Structure
REQ-034 Package bmem_pkg SHALL hold the state enum, BEAT_W, BEATS, LINE_W=256 and OFFSET_W=5.
REQ-035 Beat assembly SHALL be a sub-module line_deserializer (beat index in, 256-bit line out, clear on rst).

Verification
REQ-036 Read 0x0000_1234, bmem_ready=1, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> bmem_addr=0x0000_1220, one bmem_read, resp_valid 1 cycle after beat 4, rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-037 Write 0x0000_2040 with bmem_ready low on beat 2 for 3 cycles -> beat 2 held, 4 beats total in order, then resp_valid.
REQ-038 req_read and req_write asserted together -> write burst only, req_ready=0 until DONE.
REQ-039 Raise rst after 2 read beats -> IDLE next cycle, no resp_valid, later beats ignored, next read correct.
REQ-040 bmem_rvalid in IDLE; with BMEM_ADDR_CHECK_EN, raddr mismatch -> no state change; err=1 and stays 1 until rst.
